// File: rtl/cpu_pkg.sv
// Shared encodings for the sequencer: instruction classes, control sub-ops,
// ALU select codes and the FSM state type.
package cpu_pkg;

    localparam logic [1:0] CLS_ALU_REG = 2'b00;
    localparam logic [1:0] CLS_ALU_IMM = 2'b01;
    localparam logic [1:0] CLS_CTRL    = 2'b10;
    localparam logic [1:0] CLS_HALT    = 2'b11;

    localparam logic [1:0] SUB_LDI = 2'b00;
    localparam logic [1:0] SUB_JMP = 2'b01;
    localparam logic [1:0] SUB_JC  = 2'b10;
    localparam logic [1:0] SUB_JZ  = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_MUL = 3'd5;
    localparam logic [2:0] ALU_DIV = 3'd6;
    localparam logic [2:0] ALU_CMP = 3'd7;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        WB     = 3'd3,
        HALT   = 3'd4
    } state_e;

endpackage

// File: rtl/regfile_4x8.sv
// Four 8-bit registers: two combinational operand reads, one debug read,
// one clocked write port, asynchronously cleared.
module regfile_4x8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] raddr_a_i,
    output logic [7:0] rdata_a_o,
    input  logic [1:0] raddr_b_i,
    output logic [7:0] rdata_b_o,
    input  logic [1:0] dbg_addr_i,
    output logic [7:0] dbg_data_o,
    input  logic       we_i,
    input  logic [1:0] waddr_i,
    input  logic [7:0] wdata_i
);

    logic [3:0][7:0] mem_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o  = mem_q[raddr_a_i];
    assign rdata_b_o  = mem_q[raddr_b_i];
    assign dbg_data_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer driving an external
// combinational ALU and an acknowledge-handshaked instruction memory.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [7:0]  imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [2:0]  alu_sel,
    input  logic [7:0]  alu_out,
    input  logic        alu_carry,
    output logic        carry_flag,
    output logic        zero_flag,
    output logic        halted,
    input  logic [1:0]  dbg_sel,
    output logic [7:0]  dbg_data
);

    state_e      state_q;
    logic [7:0]  pc_q;
    logic [15:0] ir_q;
    logic        req_q;
    logic [7:0]  alu_a_q, alu_b_q;
    logic [2:0]  alu_sel_q;
    logic        carry_q, zero_q, halted_q;

    logic [1:0]  cls, sub, rd, rs;
    logic [7:0]  imm, rdata_a, rdata_b, wdata;
    logic        we, take_br;

    assign cls = ir_q[15:14];
    assign sub = ir_q[13:12];
    assign rd  = ir_q[10:9];
    assign rs  = ir_q[8:7];
    assign imm = ir_q[7:0];

    // LDI writes during DECODE; ALU results land during WB.
    assign we    = (state_q == WB) ||
                   (state_q == DECODE && cls == CLS_CTRL && sub == SUB_LDI);
    assign wdata = (state_q == WB) ? alu_out : imm;

    always_comb begin
        take_br = 1'b0;
        case (sub)
            SUB_JMP: take_br = 1'b1;
            SUB_JC:  take_br = carry_q;
            SUB_JZ:  take_br = zero_q;
            default: take_br = 1'b0;
        endcase
    end

    regfile_4x8 u_rf (
        .clk        (clk),
        .rst_n      (rst_n),
        .raddr_a_i  (rd),
        .rdata_a_o  (rdata_a),
        .raddr_b_i  (rs),
        .rdata_b_o  (rdata_b),
        .dbg_addr_i (dbg_sel),
        .dbg_data_o (dbg_data),
        .we_i       (we),
        .waddr_i    (rd),
        .wdata_i    (wdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            req_q     <= 1'b0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_sel_q <= '0;
            carry_q   <= 1'b0;
            zero_q    <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    // First cycle out of reset only raises the request.
                    if (!req_q) begin
                        req_q <= 1'b1;
                    end else if (imem_ack) begin
                        ir_q    <= imem_rdata;
                        req_q   <= 1'b0;
                        state_q <= DECODE;
                    end
                end
                DECODE: begin
                    case (cls)
                        CLS_ALU_REG, CLS_ALU_IMM: begin
                            alu_a_q   <= rdata_a;
                            alu_b_q   <= (cls == CLS_ALU_REG) ? rdata_b : imm;
                            alu_sel_q <= ir_q[13:11];
                            state_q   <= EXEC;
                        end
                        CLS_CTRL: begin
                            pc_q    <= take_br ? imm : pc_q + 8'd1;
                            req_q   <= 1'b1;
                            state_q <= FETCH;
                        end
                        default: begin
                            halted_q <= 1'b1;
                            state_q  <= HALT;
                        end
                    endcase
                end
                EXEC: state_q <= WB;
                WB: begin
                    carry_q <= alu_carry;
                    zero_q  <= (alu_out == 8'h00);
                    pc_q    <= pc_q + 8'd1;
                    req_q   <= 1'b1;
                    state_q <= FETCH;
                end
                HALT: state_q <= HALT;
                default: state_q <= FETCH;
            endcase
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = pc_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_sel    = alu_sel_q;
    assign carry_flag = carry_q;
    assign zero_flag  = zero_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: bench-side ALU model, handshaked fetches,
// hand-computed register/flag/PC expectations.
module tb_cpu_sequencer;
    import cpu_pkg::*;

    logic        clk, rst_n;
    logic        imem_req, imem_ack;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic [7:0]  alu_a, alu_b, alu_out;
    logic [2:0]  alu_sel;
    logic        alu_carry;
    logic        carry_flag, zero_flag, halted;
    logic [1:0]  dbg_sel;
    logic [7:0]  dbg_data;

    int n_cmp = 0;
    int n_err = 0;

    cpu_sequencer #(.RESET_PC(8'h00)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_out    (alu_out),
        .alu_carry  (alu_carry),
        .carry_flag (carry_flag),
        .zero_flag  (zero_flag),
        .halted     (halted),
        .dbg_sel    (dbg_sel),
        .dbg_data   (dbg_data)
    );

    always #5 clk = ~clk;

    // Combinational ALU seen by the sequencer
    always_comb begin
        logic [8:0] t;
        t = 9'd0;
        case (alu_sel)
            ALU_ADD: t = {1'b0, alu_a} + {1'b0, alu_b};
            ALU_SUB, ALU_CMP: t = {1'b0, alu_a} - {1'b0, alu_b};
            ALU_AND: t = {1'b0, alu_a & alu_b};
            ALU_OR:  t = {1'b0, alu_a | alu_b};
            ALU_XOR: t = {1'b0, alu_a ^ alu_b};
            ALU_MUL: t = {1'b0, alu_a * alu_b};
            ALU_DIV: t = (alu_b == 8'h00) ? 9'h100 : {1'b0, alu_a / alu_b};
            default: t = 9'd0;
        endcase
        alu_out   = t[7:0];
        alu_carry = t[8];
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] idx, input logic [7:0] exp);
        dbg_sel = idx;
        #1;
        chk(tag, {8'h00, dbg_data}, {8'h00, exp});
    endtask

    task automatic wait_req();
        for (int i = 0; i < 40 && imem_req !== 1'b1; i++) @(negedge clk);
        chk("req_wait", {15'd0, imem_req}, 16'd1);
    endtask

    task automatic run_instr(input string tag, input logic [15:0] ins, input int dly,
                             input bit wait_next);
        logic [7:0] a0;
        wait_req();
        a0 = imem_addr;
        for (int k = 0; k < dly; k++) begin
            @(negedge clk);
            chk({tag, "_req_hold"}, {15'd0, imem_req}, 16'd1);
            chk({tag, "_addr_hold"}, {8'h00, imem_addr}, {8'h00, a0});
        end
        imem_ack   = 1'b1;
        imem_rdata = ins;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 16'h0000;
        if (wait_next) wait_req();
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 16'h0000; dbg_sel = 2'd0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", {15'd0, imem_req}, 16'd0);
        chk("rst_addr", {8'h00, imem_addr}, 16'h0000);
        chk("rst_alu", {2'b0, alu_sel, alu_a[2:0], alu_b}, 16'h0000);
        chk("rst_flags", {13'd0, carry_flag, zero_flag, halted}, 16'd0);
        for (int r = 0; r < 4; r++) chk_reg("rst_reg", r[1:0], 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // LDI R1,F0 ; LDI R2,20 ; ADD R1,R2
        run_instr("ldi_r1", 16'h82F0, 0, 1);
        chk_reg("ldi_r1_val", 2'd1, 8'hF0);
        chk("ldi_r1_pc", {8'h00, imem_addr}, 16'h0001);
        run_instr("ldi_r2", 16'h8420, 0, 1);
        chk_reg("ldi_r2_val", 2'd2, 8'h20);
        run_instr("add", 16'h0300, 0, 1);
        chk_reg("add_r1", 2'd1, 8'h10);
        chk("add_flags", {14'd0, carry_flag, zero_flag}, 16'b10);
        chk("add_pc", {8'h00, imem_addr}, 16'h0003);
        chk("alu_hold", {alu_a, alu_b}, 16'hF020);

        // SUB-imm R0,0 then JZ 40
        run_instr("subi", 16'h4800, 0, 1);
        chk_reg("subi_r0", 2'd0, 8'h00);
        chk("subi_flags", {14'd0, carry_flag, zero_flag}, 16'b01);
        run_instr("jz", 16'hB040, 0, 1);
        chk("jz_pc", {8'h00, imem_addr}, 16'h0040);
        chk("jz_flags", {14'd0, carry_flag, zero_flag}, 16'b01);

        // LDI R2,0 ; LDI R3,55 ; DIV R3,R2 ; JC 10
        run_instr("ldi_r2z", 16'h8400, 0, 1);
        run_instr("ldi_r3", 16'h8655, 0, 1);
        run_instr("div", 16'h3700, 0, 1);
        chk_reg("div_r3", 2'd3, 8'h00);
        chk("div_flags", {14'd0, carry_flag, zero_flag}, 16'b11);
        run_instr("jc", 16'hA010, 0, 1);
        chk("jc_pc", {8'h00, imem_addr}, 16'h0010);

        // OR-imm R0,1 clears carry, then JC 80 falls through
        run_instr("ori", 16'h5801, 0, 1);
        chk_reg("ori_r0", 2'd0, 8'h01);
        chk("ori_flags", {14'd0, carry_flag, zero_flag}, 16'b00);
        run_instr("jc_nt", 16'hA080, 0, 1);
        chk("jc_nt_pc", {8'h00, imem_addr}, 16'h0012);

        // Fetch acknowledged after 5 wait cycles
        run_instr("slow", 16'h8077, 5, 1);
        chk_reg("slow_r0", 2'd0, 8'h77);
        chk("slow_pc", {8'h00, imem_addr}, 16'h0013);

        // PC wrap: JMP FF then LDI at FF
        run_instr("jmp", 16'h90FF, 0, 1);
        chk("jmp_pc", {8'h00, imem_addr}, 16'h00FF);
        run_instr("wrap", 16'h82AB, 0, 1);
        chk("wrap_pc", {8'h00, imem_addr}, 16'h0000);
        chk_reg("wrap_r1", 2'd1, 8'hAB);

        // Reset while a fetch is outstanding
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstf_req", {15'd0, imem_req}, 16'd0);
        for (int r = 0; r < 4; r++) chk_reg("rstf_reg", r[1:0], 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset while in EXEC of ADD R2,R2
        run_instr("ldi_r2b", 16'h8405, 0, 1);
        chk("rstf_restart", {8'h00, imem_addr}, 16'h0001);
        run_instr("add22", 16'h0500, 0, 0);
        @(negedge clk);
        chk("exec_ops", {alu_a, alu_b}, 16'h0505);
        rst_n = 1'b0;
        #1;
        chk("rste_req", {15'd0, imem_req}, 16'd0);
        chk("rste_alu", {alu_a, alu_b}, 16'h0000);
        chk("rste_flags", {14'd0, carry_flag, zero_flag}, 16'd0);
        for (int r = 0; r < 4; r++) chk_reg("rste_reg", r[1:0], 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        wait_req();
        chk("rste_pc", {8'h00, imem_addr}, 16'h0000);

        // HALT is terminal; stray acks are ignored
        run_instr("halt", 16'hC000, 0, 0);
        repeat (3) @(negedge clk);
        imem_ack = 1'b1; imem_rdata = 16'h8255;
        repeat (2) @(negedge clk);
        imem_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("halt_flag", {15'd0, halted}, 16'd1);
        chk("halt_req", {15'd0, imem_req}, 16'd0);
        chk("halt_pc", {8'h00, imem_addr}, 16'h0000);
        chk_reg("halt_r1", 2'd1, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
